i2s_speaker_tx: RTL and testbench
=================================

I2S_SPEAKER_TX -- requirements
Module: i2s_speaker_tx

Interface
REQ-001 Parameters: none; all widths and ratios are fixed.
REQ-002 Reset is synchronous and active-low: rst_n sampled only on the rising edge of clk.
REQ-003 clk  input  1  system clock, 100 MHz; sole clock domain.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 audio_left  input  16  left-channel sample, two's complement; sampled only at frame capture.
REQ-006 audio_right  input  16  right-channel sample, two's complement; sampled only at frame capture.
REQ-007 mute  input  1  1 = capture zero instead of audio_left/audio_right at the next frame capture.
REQ-008 sample_req  output  1  one-clk strobe; marks the cycle in which the inputs are captured.
REQ-009 mclk  output  1  DAC master clock, clk/4.
REQ-010 sck  output  1  serial bit clock, clk/16.
REQ-011 lrck  output  1  word select, clk/1024; 0 = left, 1 = right.
REQ-012 sdin  output  1  serial audio data, I2S format.

Function
REQ-013 A 10-bit free-running counter cnt increments by 1 every clk and wraps 1023 -> 0.
REQ-014 mclk, sck and lrck are cnt[1], cnt[3] and cnt[9], driven from registers: no combinational glitches.
REQ-015 Frame = 1024 clk; half-frame = 512 clk = 32 SCK slots; slot index s = cnt[8:4] (0..31).
REQ-016 sck falls at cnt[3:0]==0 and rises at cnt[3:0]==8.
REQ-017 sample_req is 1 exactly in the cycle where cnt==1023, and 0 otherwise: one pulse per 1024 clk.
REQ-018 At the rising edge that ends the cnt==1023 cycle, hold_l and hold_r are loaded together.
REQ-019 The loaded values are audio_left and audio_right when mute==0, and 16'h0000 when mute==1.
REQ-020 hold_l and hold_r are stable for the whole following frame; input or mute changes at any other cycle have no effect until the next capture.
REQ-021 sdin during slot s of the channel selected by lrck:
  - s==0: 0 (I2S one-bit delay);
  - s=1..16: bit (16-s) of that channel's hold register, so MSB first;
  - s=17..31: 0.
REQ-022 sdin is a register and changes only on the clk edge where cnt[3:0] goes 15 -> 0 (coincident with the sck falling edge); it is constant for all 16 clk of a slot.
REQ-023 Left data is taken from hold_l while cnt[9]==0; right data from hold_r while cnt[9]==1.
REQ-024 Each frame transmits left then right from the same capture; no sample is ever split across captures.
REQ-025 Boundary: the capture edge and the lrck 1 -> 0 edge coincide; slot 0 of the new left half outputs 0, so a new hold value never truncates the previous right word.

Reset
REQ-026 While rst_n==0 at a clk edge:
  - cnt, hold_l and hold_r load 0;
  - sample_req, mclk, sck, lrck and sdin are 0 on the next cycle.
REQ-027 Reset asserted mid-frame aborts the frame immediately: no partial word continues after reset.
REQ-028 The first cycle after reset release has cnt==0.
REQ-029 The first frame after reset transmits all zeros; the first capture occurs 1023 clk after release.

Verification
REQ-030 Reset check: hold rst_n=0 for 3 clk, then release.
  - During reset: all outputs 0.
  - After release: mclk toggles every 2 clk, sck every 8, lrck every 512.
  - First sample_req appears in the 1024th cycle after release (cnt==1023).
REQ-031 Data check: drive left=16'hA5C3, right=16'h3C5A, mute=0 across a capture; decode sdin on sck rising edges in the next frame.
  - Left slots 1..16 give A5C3; right slots 1..16 give 3C5A.
  - Slots 0 and 17..31 are all 0.
REQ-032 Input-stability check: change audio_left to 16'h7FFF at cnt==300 of a frame.
  - The current frame still sends the old value.
  - 7FFF appears only after the next sample_req.
REQ-033 Mute check: set mute=1 before a capture with left=16'h8001; that frame's sdin is constantly 0. Clear mute; the following frame sends 8001.
REQ-034 Reset mid-operation: assert rst_n=0 at cnt==600 for 1 clk.
  - Next cycle: all outputs 0.
  - Counter restarts at 0; the following frame is all-zero data.
REQ-035 Timing check: sdin transitions occur only on edges where cnt[3:0] goes 15 -> 0. Checked by assertion over 4 frames with random samples; the scoreboard compares decoded words with captured inputs.

Source files
------------

// File: rtl/i2s_speaker_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_speaker_tx
//  Description : I2S transmitter for a 16-bit stereo DAC. Derives mclk
//                (clk/4), sck (clk/16) and lrck (clk/1024) from one 10-bit
//                free-running counter. Captures one stereo sample per frame
//                and shifts it out MSB first with the I2S one-bit delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_speaker_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
    input  logic        mute,
    output logic        sample_req,
    output logic        mclk,
    output logic        sck,
    output logic        lrck,
    output logic        sdin
);

    localparam logic [9:0] C_CNT_LAST = 10'd1023;  // capture cycle
    localparam logic [9:0] C_CNT_PRE  = 10'd1022;  // cycle before capture
    localparam logic [3:0] C_SLOT_END = 4'd15;     // last clk of an sck slot
    localparam logic [4:0] C_SLOT_MSB = 5'd1;      // first data slot
    localparam logic [4:0] C_SLOT_LSB = 5'd16;     // last data slot
    localparam logic [4:0] C_SLOT_TOP = 5'd31;     // last slot of a half-frame

    logic [9:0]  r_cnt;
    logic [15:0] r_hold_l;
    logic [15:0] r_hold_r;
    logic        r_sample_req;
    logic        r_sdin;

    logic [4:0]  w_slot_nxt;
    logic        w_chan_nxt;
    logic [15:0] w_word_nxt;
    logic [3:0]  w_bit_idx;
    logic        w_sdin_nxt;

    // Bit to present in the slot that begins at the next 15 -> 0 boundary.
    // The lookahead lets sdin stay a plain register aligned with sck falling.
    always_comb begin
        w_slot_nxt = r_cnt[8:4] + 5'd1;
        w_chan_nxt = r_cnt[9] ^ (r_cnt[8:4] == C_SLOT_TOP);
        w_word_nxt = w_chan_nxt ? r_hold_r : r_hold_l;
        // slot 1 -> bit 15 ... slot 16 -> bit 0, i.e. bit = (16 - slot) mod 16
        w_bit_idx  = 4'd0 - w_slot_nxt[3:0];
        w_sdin_nxt = 1'b0;
        if ((w_slot_nxt >= C_SLOT_MSB) && (w_slot_nxt <= C_SLOT_LSB)) begin
            w_sdin_nxt = w_word_nxt[w_bit_idx];
        end
    end

    // Counter, frame capture, capture strobe and serial data register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= 10'd0;
            r_hold_l     <= 16'h0000;
            r_hold_r     <= 16'h0000;
            r_sample_req <= 1'b0;
            r_sdin       <= 1'b0;
        end else begin
            r_cnt        <= r_cnt + 10'd1;
            // Registered one cycle early so the strobe lands on cnt==1023.
            r_sample_req <= (r_cnt == C_CNT_PRE);
            // Capture edge coincides with lrck 1 -> 0; the new left word's
            // slot 0 is the delay bit, so the old right word is never cut.
            if (r_cnt == C_CNT_LAST) begin
                r_hold_l <= mute ? 16'h0000 : audio_left;
                r_hold_r <= mute ? 16'h0000 : audio_right;
            end
            if (r_cnt[3:0] == C_SLOT_END) begin
                r_sdin <= w_sdin_nxt;
            end
        end
    end

    assign sample_req = r_sample_req;
    assign mclk       = r_cnt[1];
    assign sck        = r_cnt[3];
    assign lrck       = r_cnt[9];
    assign sdin       = r_sdin;

endmodule
`default_nettype wire

// File: tb/tb_i2s_speaker_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_speaker_tx
//  Description : Scoreboard bench for i2s_speaker_tx. The driver issues
//                directed and random samples; a frame-level model pushes the
//                expected stereo word per frame; a monitor decodes sdin on
//                sck rising edges and pops/compares each half-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_speaker_tx;

    logic        clk;
    logic        rst_n;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        mute;
    logic        sample_req;
    logic        mclk;
    logic        sck;
    logic        lrck;
    logic        sdin;

    int tests = 0;
    int fails = 0;

    // cycle model: t = expected counter value of the current cycle
    int          t        = 0;
    bit          prev_rst = 1'b0;   // rst_n as sampled at the last posedge
    logic [31:0] exp_q[$];          // {left, right} expected per frame

    i2s_speaker_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .mute        (mute),
        .sample_req  (sample_req),
        .mclk        (mclk),
        .sck         (sck),
        .lrck        (lrck),
        .sdin        (sdin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, got, exp, t, $time);
        end
    endtask

    // Monitor + frame model, evaluated at the falling edge of clk
    initial begin : monitor
        int          slot;
        bit          half;
        bit          last_sck;
        bit          last_sdin;
        logic [31:0] bits;
        logic [9:0]  tc;
        logic [15:0] w;
        slot = 0; half = 1'b0; last_sck = 1'b0; last_sdin = 1'b0; bits = '0;
        forever begin
            @(negedge clk);
            if (!prev_rst) begin
                t = 0;
                exp_q.delete();
                exp_q.push_back(32'h0);     // first frame after reset is silent
                slot = 0;
                half = 1'b0;
                bits = '0;
            end else begin
                t = (t + 1) % 1024;
            end
            tc = t[9:0];

            // clock outputs and strobe: mclk=cnt/2, sck=cnt/8, lrck=cnt/512
            check("clocks{req,lrck,sck,mclk}", {28'h0, sample_req, lrck, sck, mclk},
                  {28'h0, (t == 1023), tc[9], tc[3], tc[1]});

            if (!prev_rst) begin
                check("reset_sdin", {31'h0, sdin}, 32'h0);
            end else if ((t % 16) != 0) begin
                check("sdin_stable", {31'h0, sdin}, {31'h0, last_sdin});
            end

            // decode on sck rising
            if (prev_rst && sck && !last_sck) begin
                bits[31 - slot] = sdin;
                slot++;
                if (slot == 32) begin
                    if (exp_q.size() == 0) begin
                        check("queue_empty", 32'h1, 32'h0);
                    end else begin
                        w = half ? exp_q[0][15:0] : exp_q[0][31:16];
                        check(half ? "right_word" : "left_word", bits, {1'b0, w, 15'h0});
                        if (half) void'(exp_q.pop_front());
                    end
                    half = ~half;
                    slot = 0;
                    bits = '0;
                end
            end

            // model capture: inputs present in the cnt==1023 cycle
            if (prev_rst && t == 1023 && rst_n) begin
                exp_q.push_back(mute ? 32'h0 : {audio_left, audio_right});
            end

            last_sck  = sck;
            last_sdin = sdin;
            prev_rst  = rst_n;
        end
    end

    // Returns in the cycle after the one where the counter equals n
    task automatic wait_cnt(input int n);
        int k;
        k = 0;
        while (k < 2100) begin
            @(posedge clk);
            if (t == n) break;
            k++;
        end
        if (k >= 2100) check("wait_cnt_timeout", 32'h1, 32'h0);
        #2;
    endtask

    task automatic rand_inputs();
        audio_left  = 16'($urandom);
        audio_right = 16'($urandom);
        mute        = ($urandom_range(0, 7) == 0);
    endtask

    initial begin : driver
        rst_n = 1'b0; audio_left = 16'h0; audio_right = 16'h0; mute = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // frame 0 is silent regardless of inputs
        audio_left = 16'h1234; audio_right = 16'h5678;
        wait_cnt(900);
        audio_left = 16'hA5C3; audio_right = 16'h3C5A; mute = 1'b0;
        // frame 1: change left mid-frame, must not show until frame 2
        wait_cnt(299);
        audio_left = 16'h7FFF;
        wait_cnt(1023);
        // frame 2: arm a muted capture
        wait_cnt(800);
        audio_left = 16'h8001; mute = 1'b1;
        // frame 3: silent; unmute for frame 4
        wait_cnt(100);
        mute = 1'b0;
        wait_cnt(1023);
        // frame 4: reset at cnt==600 for one clk
        wait_cnt(599);
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        rand_inputs();

        // random traffic over several frames
        repeat (60) begin
            repeat ($urandom_range(20, 150)) @(posedge clk);
            #2 rand_inputs();
        end
        // drain outstanding frames
        repeat (2100) @(posedge clk);
        check("queue_drained", {31'h0, (exp_q.size() <= 1)}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
